// File: rtl/fb_pkg.sv
// Shared constants and state encoding for the frame-buffer write arbiter.
// Requester order: FILL, LINE, SYMBOL. Optional macro FB_ARB_ROUND_ROBIN_EN selects round robin.
package fb_pkg;
  localparam int REQ_COUNT = 3;
  localparam int FILL      = 0;
  localparam int LINE      = 1;
  localparam int SYMBOL    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection, one-hot output.
// FB_ARB_ROUND_ROBIN_EN defined: first valid at/after ptr_i; otherwise lowest valid index.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);

`ifdef FB_ARB_ROUND_ROBIN_EN
  always_comb begin
    logic [PW-1:0] idx;
    logic          found;
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_i) + k) % N);
      if (!found && valid_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  // Isolate the lowest set bit.
  assign grant_o = valid_i & (~valid_i + N'(1));
`endif

endmodule

// File: rtl/fb_write_arbiter.sv
// Arbitrates several pixel drawers onto one frame-buffer write port with burst limiting.
// Optional macro FB_ARB_ROUND_ROBIN_EN: round-robin winner selection instead of fixed priority.
module fb_write_arbiter #(
  parameter int REQ_COUNT  = fb_pkg::REQ_COUNT,
  parameter int ADDR_WIDTH = 19,
  parameter int MAX_BURST  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [REQ_COUNT-1:0]            req_valid,
  input  logic [REQ_COUNT*ADDR_WIDTH-1:0] req_addr,
  input  logic [REQ_COUNT-1:0]            req_data,
  output logic [REQ_COUNT-1:0]            req_ready,
  input  logic                            swap,
  output logic                            fb_write_enable,
  output logic [ADDR_WIDTH-1:0]           fb_write_addr,
  output logic                            fb_write_data,
  output logic                            busy
);
  import fb_pkg::*;

  localparam int PW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e           state_q, state_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [BW-1:0]        burst_q, burst_d;
  logic [PW-1:0]        pick_ptr;
  logic [PW-1:0]        pick_idx;
  logic [REQ_COUNT-1:0] owner_oh, pick_oh, grant;
  logic                 others_valid, keep;

  logic                  fb_en_q, fb_en_d;
  logic [ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
  logic                  fb_data_q, fb_data_d;

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  assign others_valid = |(req_valid & ~owner_oh);
  assign keep = (state_q == OWN) && req_valid[owner_q] &&
                ((burst_q < BW'(MAX_BURST)) || !others_valid);

`ifdef FB_ARB_ROUND_ROBIN_EN
  logic [PW-1:0] ptr_q, ptr_d, next_ptr;
  logic          release_own;

  assign release_own = (state_q == OWN) && !keep;
  assign next_ptr    = (owner_q == PW'(REQ_COUNT - 1)) ? '0 : owner_q + 1'b1;
  // On release the advanced pointer already steers this cycle's re-arbitration.
  assign pick_ptr    = release_own ? next_ptr : ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (!swap && release_own) ptr_d = next_ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  assign pick_ptr = '0;
`endif

  rr_pick #(
    .N  (REQ_COUNT),
    .PW (PW)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (pick_ptr),
    .grant_o (pick_oh)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < REQ_COUNT; i++)
      if (pick_oh[i]) pick_idx = PW'(i);
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    burst_d = burst_q;
    grant   = '0;
    if (!swap) begin
      if (keep) begin
        grant = owner_oh;
        if (burst_q != BW'(MAX_BURST)) burst_d = burst_q + 1'b1;
      end else if (|pick_oh) begin
        grant   = pick_oh;
        state_d = OWN;
        owner_d = pick_idx;
        burst_d = BW'(1);
      end else begin
        state_d = IDLE;
        burst_d = '0;
      end
    end
  end

  // Ready must read zero while reset is held, even though the FSM sits in IDLE.
  assign req_ready = rst_n ? grant : '0;

  always_comb begin
    fb_en_d   = |grant;
    fb_addr_d = '0;
    fb_data_d = 1'b0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (grant[i]) begin
        fb_addr_d = fb_addr_d | req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        fb_data_d = fb_data_d | req_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      burst_q   <= '0;
      fb_en_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      burst_q   <= burst_d;
      fb_en_q   <= fb_en_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
    end
  end

  assign fb_write_enable = fb_en_q;
  assign fb_write_addr   = fb_addr_q;
  assign fb_write_data   = fb_data_q;
  assign busy            = (state_q == OWN) | fb_en_q;

endmodule
